serial_subtractor: RTL and testbench

Bit-serial WIDTH-bit subtractor that computes A − B − borrow-in one bit per clock, LSB first. It uses a single borrow flip-flop, with a start/done handshake around it. It is the inverse-direction counterpart to the team's ripple-carry adder path. It sits beside that adder in the arithmetic datapath, so the same operands can be added combinationally or subtracted sequentially at minimal area.

---
 rtl/serial_subtractor_if.sv | 25 ++
 rtl/serial_subtractor.sv | 110 +++++++++++
 tb/tb_serial_subtractor.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for the bit-serial subtractor.
// The master drives the operands and the start request; the slave (the
// subtractor) returns the registered difference, borrow-out and status.
interface serial_subtractor_if #(
  parameter int WIDTH = 3
);
  logic [WIDTH-1:0] inp_A;
  logic [WIDTH-1:0] inp_B;
  logic             inp_bin;
  logic             inp_start;
  logic [WIDTH-1:0] out_D;
  logic             out_bout;
  logic             out_busy;
  logic             out_done;

  modport master (
    output inp_A, inp_B, inp_bin, inp_start,
    input  out_D, out_bout, out_busy, out_done
  );

  modport slave (
    input  inp_A, inp_B, inp_bin, inp_start,
    output out_D, out_bout, out_busy, out_done
  );
endinterface

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: D = A - B - bin, one bit per clock, LSB
// first, through a single borrow flop. Companion to the combinational adder
// in the arithmetic datapath.
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | waiting for inp_start; last result held on out_D/out_bout
// S_RUN  | one difference bit per clock, WIDTH clocks
// S_DONE | out_done pulse; result valid; returns to S_IDLE unconditionally
module serial_subtractor #(
  parameter int WIDTH = 3
) (
  input logic                inp_clk,
  input logic                inp_rst,
  serial_subtractor_if.slave bus
);

  localparam int CNT_W = (WIDTH < 2) ? 1 : $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] d_sh;
  logic [WIDTH-1:0] d_nxt;
  logic             borrow;
  logic             borrow_nxt;
  logic             diff_bit;
  logic             run_last;
  logic [CNT_W-1:0] cnt;

  // State register; reset wins over every transition, including an active RUN.
  always_ff @(posedge inp_clk) begin
    if (inp_rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state decode; start is only looked at in IDLE, so it never queues.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (bus.inp_start) state_d = S_RUN;
      S_RUN:  if (run_last)      state_d = S_DONE;
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // One full-subtractor bit slice plus the difference register with the new bit at the MSB.
  always_comb begin
    diff_bit   = a_sh[0] ^ b_sh[0] ^ borrow;
    borrow_nxt = (~a_sh[0] & b_sh[0]) | (~(a_sh[0] ^ b_sh[0]) & borrow);
    run_last   = (cnt == CNT_LAST);
    d_nxt      = d_sh >> 1;
    d_nxt[WIDTH-1] = diff_bit;
  end

  // Operand shifters, borrow flop, bit counter and the result registers.
  always_ff @(posedge inp_clk) begin
    if (inp_rst) begin
      a_sh         <= '0;
      b_sh         <= '0;
      d_sh         <= '0;
      borrow       <= 1'b0;
      cnt          <= '0;
      bus.out_D    <= '0;
      bus.out_bout <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus.inp_start) begin
            a_sh   <= bus.inp_A;
            b_sh   <= bus.inp_B;
            borrow <= bus.inp_bin;
            cnt    <= '0;
          end
        end
        S_RUN: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          d_sh   <= d_nxt;
          borrow <= borrow_nxt;
          cnt    <= cnt + CNT_W'(1);
          if (run_last) begin
            bus.out_D    <= d_nxt;
            bus.out_bout <= borrow_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // Status flags decode straight from the state register, so they are never both high.
  always_comb begin
    bus.out_busy = (state_q == S_RUN);
    bus.out_done = (state_q == S_DONE);
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor at WIDTH = 3, 1 and 8. Expected results are
// computed from integer arithmetic, queued when a start is driven and
// popped when the matching done pulse is seen.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  serial_subtractor_if #(.WIDTH(3)) if3 ();
  serial_subtractor_if #(.WIDTH(1)) if1 ();
  serial_subtractor_if #(.WIDTH(8)) if8 ();

  serial_subtractor #(.WIDTH(3)) dut3 (.inp_clk(clk), .inp_rst(rst), .bus(if3));
  serial_subtractor #(.WIDTH(1)) dut1 (.inp_clk(clk), .inp_rst(rst), .bus(if1));
  serial_subtractor #(.WIDTH(8)) dut8 (.inp_clk(clk), .inp_rst(rst), .bus(if8));

  // Shared stimulus bus; sel picks which DUT gets the start and is monitored.
  int         sel = 3;
  logic [7:0] tb_A = '0;
  logic [7:0] tb_B = '0;
  logic       tb_bin = 1'b0;
  logic       tb_start = 1'b0;

  assign if3.inp_A = tb_A[2:0];
  assign if3.inp_B = tb_B[2:0];
  assign if3.inp_bin = tb_bin;
  assign if3.inp_start = tb_start && (sel == 3);
  assign if1.inp_A = tb_A[0:0];
  assign if1.inp_B = tb_B[0:0];
  assign if1.inp_bin = tb_bin;
  assign if1.inp_start = tb_start && (sel == 1);
  assign if8.inp_A = tb_A;
  assign if8.inp_B = tb_B;
  assign if8.inp_bin = tb_bin;
  assign if8.inp_start = tb_start && (sel == 8);

  logic [7:0] mon_D;
  logic       mon_bout;
  logic       mon_done;
  always_comb begin
    case (sel)
      1: begin mon_D = {7'b0, if1.out_D}; mon_bout = if1.out_bout; mon_done = if1.out_done; end
      8: begin mon_D = if8.out_D;         mon_bout = if8.out_bout; mon_done = if8.out_done; end
      default: begin mon_D = {5'b0, if3.out_D}; mon_bout = if3.out_bout; mon_done = if3.out_done; end
    endcase
  end

  logic [8:0] sb[$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [8:0] ref_sub(input int w, input int a, input int b, input int bin);
    int diff;
    logic bo;
    diff = a - b - bin;
    bo = (a < b + bin);
    if (diff < 0) diff = diff + (1 << w);
    return {bo, 8'(diff)};
  endfunction

  // Drive one start into DUT of width w, then wait (bounded) for done and check the result.
  task automatic run_op(input int w, input int a_in, input int b_in, input int bin, input string tag);
    int mask;
    logic got;
    logic [8:0] exp;
    mask = (1 << w) - 1;
    @(negedge clk);
    sel = w;
    tb_A = 8'(a_in & mask);
    tb_B = 8'(b_in & mask);
    tb_bin = bin[0];
    tb_start = 1'b1;
    sb.push_back(ref_sub(w, a_in & mask, b_in & mask, bin));
    @(negedge clk);
    tb_start = 1'b0;
    got = 1'b0;
    for (int k = 0; k < w + 4 && !got; k++) begin
      if (mon_done) got = 1'b1;
      else @(negedge clk);
    end
    exp = sb.pop_front();
    n_cmp++;
    if (!got) begin
      n_err++;
      $display("FAIL %s timeout: done not seen, expected D=%0d bout=%0d", tag, exp[7:0], exp[8]);
    end else begin
      if (mon_D !== exp[7:0]) begin
        n_err++;
        $display("FAIL %s D: got %0d expected %0d", tag, mon_D, exp[7:0]);
      end
      n_cmp++;
      if (mon_bout !== exp[8]) begin
        n_err++;
        $display("FAIL %s bout: got %0d expected %0d", tag, mon_bout, exp[8]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({if3.out_D, if3.out_bout, if3.out_busy, if3.out_done} !== 6'b0) begin
      n_err++;
      $display("FAIL reset_w3: got D=%0d bout=%0d busy=%0d done=%0d expected all 0",
               if3.out_D, if3.out_bout, if3.out_busy, if3.out_done);
    end
    n_cmp++;
    if ({if1.out_D, if1.out_bout, if1.out_busy, if1.out_done, if8.out_D, if8.out_busy} !== 13'b0) begin
      n_err++;
      $display("FAIL reset_w1_w8: got D1=%0d D8=%0d busy1=%0d busy8=%0d expected 0",
               if1.out_D, if8.out_D, if1.out_busy, if8.out_busy);
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  // 5 - 2: three busy cycles, one done cycle carrying 3/0, then idle.
  task automatic test_basic();
    logic [8:0] exp;
    sel = 3;
    tb_A = 8'd5; tb_B = 8'd2; tb_bin = 1'b0; tb_start = 1'b1;
    sb.push_back(ref_sub(3, 5, 2, 0));
    @(negedge clk);
    tb_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (if3.out_busy !== 1'b1 || if3.out_done !== 1'b0) begin
        n_err++;
        $display("FAIL basic_busy[%0d]: got busy=%0d done=%0d expected 1/0", i, if3.out_busy, if3.out_done);
      end
      @(negedge clk);
    end
    exp = sb.pop_front();
    n_cmp++;
    if (if3.out_done !== 1'b1 || if3.out_busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_done: got busy=%0d done=%0d expected 0/1", if3.out_busy, if3.out_done);
    end
    n_cmp++;
    if ({if3.out_bout, if3.out_D} !== {exp[8], exp[2:0]}) begin
      n_err++;
      $display("FAIL basic_result: got D=%0d bout=%0d expected D=%0d bout=%0d",
               if3.out_D, if3.out_bout, exp[2:0], exp[8]);
    end
    @(negedge clk);
    n_cmp++;
    if (if3.out_done !== 1'b0 || if3.out_busy !== 1'b0) begin
      n_err++;
      $display("FAIL basic_idle: got busy=%0d done=%0d expected 0/0", if3.out_busy, if3.out_done);
    end
  endtask

  task automatic test_directed();
    run_op(3, 2, 5, 0, "dir_2m5");
    run_op(3, 0, 0, 1, "dir_0m0m1");
    run_op(3, 7, 7, 0, "dir_7m7");
  endtask

  // Start held high; operand change during RUN ignored; next op only after the idle cycle.
  task automatic test_start_held();
    logic [8:0] exp;
    logic got;
    @(negedge clk);
    sel = 3;
    tb_A = 8'd6; tb_B = 8'd1; tb_bin = 1'b0; tb_start = 1'b1;
    sb.push_back(ref_sub(3, 6, 1, 0));
    @(negedge clk);
    tb_A = 8'd0;
    n_cmp++;
    if (if3.out_D !== 3'd0 || if3.out_bout !== 1'b0) begin
      n_err++;
      $display("FAIL held_hold_prev: got D=%0d bout=%0d expected D=0 bout=0", if3.out_D, if3.out_bout);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (if3.out_busy !== 1'b1) begin
      n_err++;
      $display("FAIL held_busy3: got busy=%0d expected 1", if3.out_busy);
    end
    @(negedge clk);
    exp = sb.pop_front();
    n_cmp++;
    if (if3.out_done !== 1'b1 || {if3.out_bout, if3.out_D} !== {exp[8], exp[2:0]}) begin
      n_err++;
      $display("FAIL held_result: got done=%0d D=%0d bout=%0d expected done=1 D=%0d bout=%0d",
               if3.out_done, if3.out_D, if3.out_bout, exp[2:0], exp[8]);
    end
    @(negedge clk);
    n_cmp++;
    if (if3.out_busy !== 1'b0 || if3.out_done !== 1'b0) begin
      n_err++;
      $display("FAIL held_idle_gap: got busy=%0d done=%0d expected 0/0", if3.out_busy, if3.out_done);
    end
    sb.push_back(ref_sub(3, 0, 1, 0));
    @(negedge clk);
    tb_start = 1'b0;
    n_cmp++;
    if (if3.out_busy !== 1'b1) begin
      n_err++;
      $display("FAIL held_reaccept: got busy=%0d expected 1", if3.out_busy);
    end
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      if (if3.out_done) got = 1'b1;
      else @(negedge clk);
    end
    exp = sb.pop_front();
    n_cmp++;
    if (!got || {if3.out_bout, if3.out_D} !== {exp[8], exp[2:0]}) begin
      n_err++;
      $display("FAIL held_second: got done=%0d D=%0d bout=%0d expected D=%0d bout=%0d",
               got, if3.out_D, if3.out_bout, exp[2:0], exp[8]);
    end
  endtask

  // Reset in the 2nd RUN cycle aborts the op and clears the held result.
  task automatic test_reset_abort();
    run_op(3, 5, 2, 0, "abort_prior");
    @(negedge clk);
    sel = 3;
    tb_A = 8'd6; tb_B = 8'd1; tb_bin = 1'b0; tb_start = 1'b1;
    @(negedge clk);
    tb_start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({if3.out_D, if3.out_bout, if3.out_busy, if3.out_done} !== 6'b0) begin
      n_err++;
      $display("FAIL abort_clear: got D=%0d bout=%0d busy=%0d done=%0d expected all 0",
               if3.out_D, if3.out_bout, if3.out_busy, if3.out_done);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (if3.out_done !== 1'b0 || if3.out_D !== 3'd0) begin
      n_err++;
      $display("FAIL abort_no_result: got done=%0d D=%0d expected 0/0", if3.out_done, if3.out_D);
    end
    run_op(3, 4, 1, 0, "abort_after");
  endtask

  task automatic test_back_to_back();
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        for (int c = 0; c < 2; c++)
          run_op(3, a, b, c, $sformatf("w3_%0d_%0d_%0d", a, b, c));
    for (int a = 0; a < 2; a++)
      for (int b = 0; b < 2; b++)
        for (int c = 0; c < 2; c++)
          run_op(1, a, b, c, $sformatf("w1_%0d_%0d_%0d", a, b, c));
    run_op(8, 0, 255, 1, "w8_min");
    run_op(8, 255, 0, 0, "w8_max");
    run_op(8, 128, 128, 1, "w8_eqbin");
    for (int i = 0; i < 2000; i++)
      run_op(8, int'($urandom_range(0, 255)), int'($urandom_range(0, 255)),
             int'($urandom_range(0, 1)), $sformatf("w8_rand%0d", i));
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_directed();
    test_start_held();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
